byte_serial_adder_ctrl: RTL
===========================

BYTE_SERIAL_ADDER_CTRL -- requirements
Module: byte_serial_adder_ctrl

Interface
REQ-001 Parameter: NBYTES, default 4, number of 8-bit slices per operand; legal range is 2 to 16.
REQ-002 Port: clk, input, 1, the single clock; every register is clocked on its rising edge.
REQ-003 Port: rst, input, 1, reset, asynchronous and active-high.
REQ-004 Port: in_valid, input, 1, operand request valid.
REQ-005 Port: in_ready, output, 1, block can accept an operand request.
REQ-006 Port: op_a, input, 8*NBYTES, operand A.
REQ-007 Port: op_b, input, 8*NBYTES, operand B.
REQ-008 Port: op_cin, input, 1, initial carry-in.
REQ-009 Port: fa_A, output, 8, A slice driven to the 8-bit full_adder.
REQ-010 Port: fa_B, output, 8, B slice driven to the full_adder.
REQ-011 Port: fa_Cin, output, 1, carry-in driven to the full_adder.
REQ-012 Port: fa_Sum, input, 8, Sum returned by the full_adder.
REQ-013 Port: fa_Cout, input, 1, Cout returned by the full_adder.
REQ-014 Port: out_valid, output, 1, result valid.
REQ-015 Port: out_ready, input, 1, downstream accepts the result.
REQ-016 Port: result, output, 8*NBYTES, wide sum.
REQ-017 Port: cout, output, 1, final unsigned carry-out.
REQ-018 Port: overflow, output, 1, two's-complement overflow flag.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-020 in_ready SHALL equal (state==IDLE); it is combinational from state.
REQ-021 In IDLE, on a clock edge with in_valid=1: op_a, op_b and op_cin SHALL be latched, slice index idx SHALL be set to 0, carry_reg SHALL be set to op_cin, and the FSM SHALL move to CALC.
REQ-022 In CALC, outputs SHALL be registered-source combinational: fa_A=a_reg[8*idx+:8], fa_B=b_reg[8*idx+:8], fa_Cin=carry_reg.
REQ-023 On each CALC edge: result slice idx SHALL take fa_Sum, carry_reg SHALL take fa_Cout, and idx SHALL increment.
REQ-024 On the CALC edge where idx==NBYTES-1: the FSM SHALL move to DONE, cout SHALL take fa_Cout, and overflow SHALL take fa_Cout XOR (a_msb XOR b_msb XOR fa_Sum[7]).
REQ-025 Latency: out_valid SHALL rise exactly NBYTES clock edges after the accepting edge.
REQ-026 In IDLE and DONE: fa_A, fa_B and fa_Cin SHALL be driven to 0.
REQ-027 In DONE: out_valid SHALL be 1, and result, cout and overflow SHALL be held stable until out_ready=1.
REQ-028 In DONE with out_ready=1 at an edge: the FSM SHALL return to IDLE, and out_valid SHALL be 0 in the following cycle.
REQ-029 No new operand SHALL be accepted in CALC or DONE; there is no overlap between requests (throughput is one operation per NBYTES+2 cycles at best).
REQ-030 result, cout and overflow SHALL keep their last values in IDLE.
REQ-031 in_valid arriving together with a DONE->IDLE transition SHALL NOT be accepted in the same cycle.
REQ-032 Any operand change while not in IDLE SHALL be ignored.

Reset
REQ-033 While rst=1: state=IDLE, idx=0, carry_reg=0, a_reg=b_reg=0, result=0, cout=0, overflow=0, out_valid=0, in_ready=1, and fa_* outputs=0.
REQ-034 rst asserted mid-CALC or mid-DONE SHALL abort the operation immediately with no partial result presented.
REQ-035 The first rising edge after rst deasserts SHALL be able to accept a request.

Verification (NBYTES=4)
REQ-036 Scenario 1: 0x000000FF + 0x00000001, cin=0 -> result=0x00000100, cout=0, overflow=0, out_valid 4 edges after accept.
REQ-037 Scenario 2: 0xFFFFFFFF + 0x00000000, cin=1 -> result=0x00000000, cout=1, overflow=0; fa_Cin=1 observed in all four CALC cycles.
REQ-038 Scenario 3: 0x7FFFFFFF + 0x00000001, cin=0 -> result=0x80000000, cout=0, overflow=1.
REQ-039 Scenario 4: hold out_ready=0 for 5 cycles after out_valid -> result stable and in_ready=0 throughout; pulse out_ready -> out_valid=0 and in_ready=1 next cycle.
REQ-040 Scenario 5: assert rst after 2 CALC cycles of 0x12345678 + 0x11111111 -> all outputs 0 immediately; then 0x00000005 + 0x00000003 -> result=0x00000008.
REQ-041 Scenario 6: hold in_valid=1 continuously with back-to-back requests -> accepts are spaced at least NBYTES+2 cycles apart, and every result matches a reference model.

Source files
------------

// File: rtl/byte_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// byte_serial_adder_ctrl
//
// Purpose:
//   Adds two NBYTES*8-bit operands one byte at a time through an external
//   8-bit full adder. An accepted request is worked through least-significant
//   slice first, one slice per clock. The wide sum, the unsigned carry-out and
//   the two's-complement overflow flag are then presented until downstream
//   takes them.
//
// State table:
//   state | meaning
//   IDLE  | waiting for a request; in_ready=1; last result held on outputs
//   CALC  | one byte slice per clock through the external full adder
//   DONE  | result presented with out_valid=1 until out_ready
//
// Parameters:
//   NBYTES    number of 8-bit slices per operand (legal range 2..16)
//
// Ports:
//   clk       clock; every register updates on the rising edge
//   rst       asynchronous, active-high reset
//   in_valid  request valid
//   in_ready  request can be accepted (state == IDLE)
//   op_a      operand A, 8*NBYTES bits
//   op_b      operand B, 8*NBYTES bits
//   op_cin    initial carry-in
//   fa_A      A slice to the full adder (0 outside CALC)
//   fa_B      B slice to the full adder (0 outside CALC)
//   fa_Cin    carry-in to the full adder (0 outside CALC)
//   fa_Sum    8-bit sum from the full adder
//   fa_Cout   carry-out from the full adder
//   out_valid result valid (state == DONE)
//   out_ready downstream accepts the result
//   result    wide sum, 8*NBYTES bits
//   cout      final unsigned carry-out
//   overflow  two's-complement overflow of the wide add
// -----------------------------------------------------------------------------
module byte_serial_adder_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] op_a,
  input  logic [8*NBYTES-1:0] op_b,
  input  logic                op_cin,
  output logic [7:0]          fa_A,
  output logic [7:0]          fa_B,
  output logic                fa_Cin,
  input  logic [7:0]          fa_Sum,
  input  logic                fa_Cout,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] result,
  output logic                cout,
  output logic                overflow
);

  localparam int W    = 8 * NBYTES;
  localparam int IDXW = $clog2(NBYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [IDXW-1:0] idx;
  logic            carry_reg;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic [W-1:0]    result_r;
  logic            cout_r;
  logic            overflow_r;
  logic            last_slice;

  assign last_slice = (idx == IDXW'(NBYTES - 1));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (last_slice) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        // Returning to IDLE here means a request that is already waiting is
        // taken one edge later, never on the same edge as the hand-off.
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    fa_A      = 8'h00;
    fa_B      = 8'h00;
    fa_Cin    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
      end
      CALC: begin
        // Sourced only from registers, so the adder path is one flop-to-flop
        // stage through the external full adder.
        fa_A   = a_reg[8*idx +: 8];
        fa_B   = b_reg[8*idx +: 8];
        fa_Cin = carry_reg;
      end
      DONE: begin
        out_valid = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      carry_reg  <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      result_r   <= '0;
      cout_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= op_a;
            b_reg     <= op_b;
            carry_reg <= op_cin;
            idx       <= '0;
          end
        end
        CALC: begin
          result_r[8*idx +: 8] <= fa_Sum;
          carry_reg            <= fa_Cout;
          idx                  <= idx + IDXW'(1);
          if (last_slice) begin
            cout_r     <= fa_Cout;
            // a_msb ^ b_msb ^ sum_msb recovers the carry into the top bit;
            // overflow is that carry differing from the carry out of it.
            overflow_r <= fa_Cout ^ (a_reg[W-1] ^ b_reg[W-1] ^ fa_Sum[7]);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign result   = result_r;
  assign cout     = cout_r;
  assign overflow = overflow_r;

endmodule
